// File: rtl/demux_stream.sv
// demux_stream
//   Registered 1:NUM_CH stream demultiplexer with valid/ready flow control.
//   Each accepted beat goes to channel in_sel, or to every channel when bcast=1.
//   Each channel has a one-entry output register, so a stall on one channel
//   does not block beats headed for the others.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   bcast      broadcast this beat to all channels (in_sel ignored)
//   in_valid   upstream beat valid
//   in_ready   beat can be accepted this cycle
//   in_data    upstream payload (DATA_W)
//   in_sel     destination channel index (SEL_W)
//   out_valid  per-channel valid (NUM_CH)
//   out_ready  per-channel downstream ready (NUM_CH)
//   out_data   channel k at [k*DATA_W +: DATA_W]
//   err_sel    one-cycle pulse after an out-of-range beat was accepted and dropped
module demux_stream #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     bcast,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [SEL_W-1:0]         in_sel,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic                     err_sel
);

   logic [NUM_CH-1:0]        ch_full;
   logic [NUM_CH-1:0]        slot_free;
   logic [NUM_CH-1:0]        sel_hit;
   logic [NUM_CH-1:0]        load;
   logic [NUM_CH*DATA_W-1:0] data_q;
   logic                     sel_free;
   logic                     all_free;
   logic                     in_range;
   logic                     accept;
   logic                     err_q;

   // A full slot can still take a beat if it drains in the same cycle.
   assign slot_free = ~ch_full | out_ready;

   always_comb begin
      sel_hit  = '0;
      sel_free = 1'b1;   // out-of-range selects are always accepted, then dropped
      all_free = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
         all_free = all_free & slot_free[k];
         if (in_sel == SEL_W'(k)) begin
            sel_hit[k] = 1'b1;
            sel_free   = slot_free[k];
         end
      end
   end

   assign in_range = |sel_hit;
   // in_ready is built from bcast/in_sel/out_ready/state only, never in_valid.
   assign in_ready = bcast ? all_free : sel_free;
   assign accept   = in_valid & in_ready;
   assign load     = accept ? (bcast ? {NUM_CH{1'b1}} : sel_hit) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_full <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= accept & ~bcast & ~in_range;
         for (int k = 0; k < NUM_CH; k++) begin
            if (load[k]) begin
               ch_full[k]                 <= 1'b1;
               data_q[k*DATA_W +: DATA_W] <= in_data;
            end else if (out_ready[k]) begin
               ch_full[k] <= 1'b0;   // data is kept, only the valid drops
            end
         end
      end
   end

   assign out_valid = ch_full;
   assign out_data  = data_q;
   assign err_sel   = err_q;

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream
//   Directed bench for demux_stream: a NUM_CH=4 instance for the main
//   behaviour and a NUM_CH=3 instance for out-of-range selects.
//   Ports: none (top-level bench).
module tb_demux_stream;

   logic        clk = 1'b0;
   logic        rst;

   // NUM_CH = 4 instance
   logic        bcast, in_valid, in_ready;
   logic [7:0]  in_data;
   logic [1:0]  in_sel;
   logic [3:0]  out_valid, out_ready;
   logic [31:0] out_data;
   logic        err_sel;

   // NUM_CH = 3 instance
   logic        bcast3, in_valid3, in_ready3;
   logic [7:0]  in_data3;
   logic [1:0]  in_sel3;
   logic [2:0]  out_valid3, out_ready3;
   logic [23:0] out_data3;
   logic        err_sel3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   demux_stream #(.NUM_CH(4), .DATA_W(8)) dut4 (
      .clk(clk), .rst(rst), .bcast(bcast), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .err_sel(err_sel)
   );

   demux_stream #(.NUM_CH(3), .DATA_W(8)) dut3 (
      .clk(clk), .rst(rst), .bcast(bcast3), .in_valid(in_valid3),
      .in_ready(in_ready3), .in_data(in_data3), .in_sel(in_sel3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
      .err_sel(err_sel3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      bcast     = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      in_data   = 8'h11;
      out_ready = 4'hF;
      bcast3    = 1'b0;
      in_valid3 = 1'b0;
      in_sel3   = 2'd0;
      in_data3  = 8'h00;
      out_ready3 = 3'b111;

      // 1) reset held two cycles with in_valid=1
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_out_valid", 64'(out_valid), 64'h0);
         chk("rst_out_data", 64'(out_data), 64'h0);
         chk("rst_err_sel", 64'(err_sel), 64'h0);
         chk("rst_err_sel3", 64'(err_sel3), 64'h0);
      end
      rst = 1'b0;

      // 2) walk channels 0..3 with all downstream ready
      for (int i = 0; i < 4; i++) begin
         in_sel   = 2'(i);
         in_data  = 8'hA0 + 8'(i);
         in_valid = 1'b1;
         #1;
         chk("walk_in_ready", 64'(in_ready), 64'h1);
         tick();
         chk("walk_out_valid", 64'(out_valid), 64'(4'b0001 << i));
         chk("walk_lane", 64'(out_data[i*8 +: 8]), 64'(8'hA0 + 8'(i)));
      end
      in_valid = 1'b0;
      tick();
      chk("walk_drained", 64'(out_valid), 64'h0);
      chk("walk_data_held", 64'(out_data), 64'hA3A2A1A0);

      // 3) channel 2 stalled, second beat waits, then loads as ch2 drains
      out_ready = 4'b1011;
      in_sel    = 2'd2;
      in_data   = 8'h55;
      in_valid  = 1'b1;
      #1;
      chk("stall_first_ready", 64'(in_ready), 64'h1);
      tick();
      chk("stall_valid", 64'(out_valid), 64'b0100);
      chk("stall_data", 64'(out_data), 64'hA355A1A0);
      in_data = 8'h66;
      #1;
      chk("stall_blocked", 64'(in_ready), 64'h0);
      tick();
      chk("stall_hold_valid", 64'(out_valid), 64'b0100);
      chk("stall_hold_data", 64'(out_data), 64'hA355A1A0);
      out_ready = 4'hF;
      #1;
      chk("stall_release_ready", 64'(in_ready), 64'h1);
      tick();
      chk("stall_reload_valid", 64'(out_valid), 64'b0100);
      chk("stall_reload_data", 64'(out_data), 64'hA366A1A0);
      in_valid = 1'b0;
      tick();
      chk("stall_drained", 64'(out_valid), 64'h0);

      // 4) broadcast, then blocked broadcast with ch1 full and stalled
      bcast    = 1'b1;
      in_data  = 8'hC3;
      in_valid = 1'b1;
      #1;
      chk("bc_ready", 64'(in_ready), 64'h1);
      tick();
      chk("bc_valid", 64'(out_valid), 64'hF);
      chk("bc_data", 64'(out_data), 64'hC3C3C3C3);
      chk("bc_no_err", 64'(err_sel), 64'h0);
      out_ready = 4'b1101;
      in_data   = 8'h3C;
      #1;
      chk("bc_blocked", 64'(in_ready), 64'h0);
      tick();
      chk("bc_blocked_valid", 64'(out_valid), 64'b0010);
      chk("bc_blocked_data", 64'(out_data), 64'hC3C3C3C3);
      in_valid  = 1'b0;
      bcast     = 1'b0;
      out_ready = 4'hF;
      tick();
      chk("bc_drained", 64'(out_valid), 64'h0);

      // 5) out-of-range select on the 3-channel build
      in_sel3   = 2'd3;
      in_data3  = 8'hFF;
      in_valid3 = 1'b1;
      #1;
      chk("oor_ready", 64'(in_ready3), 64'h1);
      tick();
      chk("oor_err", 64'(err_sel3), 64'h1);
      chk("oor_valid", 64'(out_valid3), 64'h0);
      chk("oor_data", 64'(out_data3), 64'h0);
      in_valid3 = 1'b0;
      tick();
      chk("oor_err_pulse", 64'(err_sel3), 64'h0);
      bcast3    = 1'b1;
      in_data3  = 8'h5A;
      in_valid3 = 1'b1;
      tick();
      chk("oor_bc_no_err", 64'(err_sel3), 64'h0);
      chk("oor_bc_valid", 64'(out_valid3), 64'b111);
      chk("oor_bc_data", 64'(out_data3), 64'h5A5A5A);
      in_valid3 = 1'b0;
      bcast3    = 1'b0;

      // 6) reset while ch0 and ch3 hold beats
      out_ready = 4'h0;
      in_sel    = 2'd0;
      in_data   = 8'h10;
      in_valid  = 1'b1;
      tick();
      in_sel  = 2'd3;
      in_data = 8'h13;
      tick();
      chk("pre_rst_valid", 64'(out_valid), 64'b1001);
      chk("pre_rst_data", 64'(out_data), 64'h13C3C310);
      rst     = 1'b1;
      in_sel  = 2'd1;
      in_data = 8'h77;
      tick();
      chk("mid_rst_valid", 64'(out_valid), 64'h0);
      chk("mid_rst_data", 64'(out_data), 64'h0);
      rst       = 1'b0;
      out_ready = 4'hF;
      #1;
      chk("post_rst_ready", 64'(in_ready), 64'h1);
      tick();
      chk("post_rst_valid", 64'(out_valid), 64'b0010);
      chk("post_rst_data", 64'(out_data), 64'h00007700);
      in_valid = 1'b0;
      tick();
      chk("post_rst_drained", 64'(out_valid), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
